// File: rtl/viterbi_pkg.sv
// Constants and types shared by the convolutional encoder and the Viterbi decoder.
// G0/G1 bit K-1 taps the current input; bit 0 taps the oldest register bit.
package viterbi_pkg;
  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int TCW = $clog2(K);

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_e;
endpackage

// File: rtl/conv_encoder_if.sv
// Bit-in / symbol-out handshake bundle of the convolutional encoder.
interface conv_encoder_if;
  import viterbi_pkg::*;

  logic i_bit;
  logic i_valid;
  logic i_last;
  logic o_ready;
  sym_t o_sym;
  logic o_valid;
  logic o_last;
  logic i_ready;
  logic o_busy;

  modport slave (
    input  i_bit, i_valid, i_last, i_ready,
    output o_ready, o_sym, o_valid, o_last, o_busy
  );

  modport master (
    output i_bit, i_valid, i_last, i_ready,
    input  o_ready, o_sym, o_valid, o_last, o_busy
  );
endinterface

// File: rtl/conv_enc_core.sv
// Combinational encoder step: parity of the tapped word and the shifted register.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic         u,
  input  logic [K-2:0] sr,
  output sym_t         sym,
  output logic [K-2:0] sr_nxt
);
  logic [K-1:0] w;

  assign w      = {u, sr};
  assign sym    = {^(w & G0), ^(w & G1)};
  assign sr_nxt = {u, sr[K-2:1]};
endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder with registered symbol output and K-1 zero tail bits.
//   state | meaning
//   IDLE  | sr is zero, waiting for the first bit of a frame
//   DATA  | accepting information bits
//   TAIL  | input blocked, flushing K-1 zero bits so the trellis ends in state 0
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  conv_encoder_if.slave  bus
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_DATA = DATA;
  localparam logic [1:0] ST_TAIL = TAIL;

  logic [1:0]     state;
  logic [K-2:0]   sr;
  logic [K-2:0]   sr_nxt;
  logic [TCW-1:0] tail_cnt;
  sym_t           sym;
  sym_t           sym_q;
  logic           valid_q;
  logic           last_q;
  logic           u;
  logic           slot_free;
  logic           accept;
  logic           tail_step;

  assign slot_free   = !valid_q || bus.i_ready;
  assign bus.o_ready = (state != ST_TAIL) && slot_free && !i_rst;
  assign accept      = bus.i_valid && bus.o_ready;
  assign tail_step   = (state == ST_TAIL) && slot_free;
  assign u           = accept ? bus.i_bit : 1'b0;

  assign bus.o_sym   = sym_q;
  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;
  assign bus.o_busy  = (state != ST_IDLE);

  conv_enc_core u_core (
    .u      (u),
    .sr     (sr),
    .sym    (sym),
    .sr_nxt (sr_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      sr       <= '0;
      tail_cnt <= '0;
      sym_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else if (accept) begin
      sym_q    <= sym;
      valid_q  <= 1'b1;
      last_q   <= 1'b0;
      sr       <= sr_nxt;
      tail_cnt <= '0;
      state    <= bus.i_last ? ST_TAIL : ST_DATA;
    end else if (tail_step) begin
      sym_q   <= sym;
      valid_q <= 1'b1;
      sr      <= sr_nxt;
      // Final tail bit shifts the last data bit out, leaving sr at zero.
      if (tail_cnt == TCW'(K - 2)) begin
        last_q   <= 1'b1;
        tail_cnt <= '0;
        state    <= ST_IDLE;
      end else begin
        last_q   <= 1'b0;
        tail_cnt <= tail_cnt + TCW'(1);
      end
    end else if (slot_free) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed vector table, corner sequences, random frames.
module tb_conv_encoder;
  import viterbi_pkg::*;

  localparam int KT = 3;
  localparam logic [2:0] TB_G0 = 3'b111;
  localparam logic [2:0] TB_G1 = 3'b101;

  typedef struct packed {
    logic [3:0]  n;
    logic [7:0]  bits;
    logic [19:0] syms;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  conv_encoder_if bus ();

  conv_encoder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [1:0] obs_sym [$];
  logic       obs_last [$];
  logic [1:0] exp_sym [$];
  logic       exp_last [$];
  logic       rdy_mode = 1'b0;
  logic       vcheck_en = 1'b0;
  logic       exp_v = 1'b0;
  int         tail_left = 0;
  logic       b2b_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (rdy_mode) begin
      #1;
      bus.i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid && bus.i_ready) begin
        obs_sym.push_back(bus.o_sym);
        obs_last.push_back(bus.o_last);
        if (bus.o_last && bus.i_valid && bus.o_ready) b2b_seen = 1'b1;
      end
      if (vcheck_en) begin
        check("valid_gap", {31'd0, bus.o_valid}, {31'd0, exp_v});
        if (bus.i_valid && bus.o_ready) begin
          exp_v = 1'b1;
          tail_left = bus.i_last ? KT - 1 : 0;
        end else if (tail_left > 0) begin
          exp_v = 1'b1;
          tail_left--;
        end else begin
          exp_v = 1'b0;
        end
      end
    end
  end

  // Reference: convolve the zero-padded bit stream with each generator polynomial.
  function automatic void model_frame(input logic [7:0] bits, input int n);
    logic b [$];
    logic s1, s0;
    for (int i = 0; i < n; i++) b.push_back(bits[i]);
    for (int i = 0; i < KT - 1; i++) b.push_back(1'b0);
    for (int t = 0; t < n + KT - 1; t++) begin
      s1 = 1'b0;
      s0 = 1'b0;
      for (int j = 0; j < KT; j++) begin
        if (t - j >= 0) begin
          if (TB_G0[KT-1-j]) s1 ^= b[t-j];
          if (TB_G1[KT-1-j]) s0 ^= b[t-j];
        end
      end
      exp_sym.push_back({s1, s0});
      exp_last.push_back(t == n + KT - 2);
    end
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the bit.
  task automatic send_bit(input logic b, input logic last, input int gapmax);
    int g;
    int c;
    logic fire;
    g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
    bus.i_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    bus.i_valid = 1'b1;
    bus.i_bit   = b;
    bus.i_last  = last;
    c = 0;
    fire = 1'b0;
    while (!fire && c < 200) begin
      @(negedge clk);
      fire = bus.i_valid && bus.o_ready;
      @(posedge clk); #1;
      c++;
    end
    if (!fire) check("send_timeout", 32'd0, 32'd1);
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bits, input int n, input int gapmax);
    for (int i = 0; i < n; i++) send_bit(bits[i], (i == n - 1), gapmax);
  endtask

  task automatic compare_obs(input string name);
    int c;
    c = 0;
    while (obs_sym.size() < exp_sym.size() && c < 1000) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check({name, "_count"}, obs_sym.size(), exp_sym.size());
    for (int i = 0; i < exp_sym.size() && i < obs_sym.size(); i++) begin
      check({name, "_sym"}, {30'd0, obs_sym[i]}, {30'd0, exp_sym[i]});
      check({name, "_last"}, {31'd0, obs_last[i]}, {31'd0, exp_last[i]});
    end
    obs_sym.delete(); obs_last.delete();
    exp_sym.delete(); exp_last.delete();
  endtask

  vec_t vecs [4];

  initial begin
    logic [7:0] rb;
    int rn;

    vecs[0] = '{n: 4'd4, bits: 8'b0000_1101, syms: 20'({2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11})};
    vecs[1] = '{n: 4'd1, bits: 8'b0000_0001, syms: 20'({2'b11, 2'b10, 2'b11})};
    vecs[2] = '{n: 4'd2, bits: 8'b0000_0011, syms: 20'({2'b11, 2'b01, 2'b01, 2'b11})};
    vecs[3] = '{n: 4'd2, bits: 8'b0000_0010, syms: 20'({2'b11, 2'b10, 2'b11, 2'b00})};

    bus.i_bit = 1'b0; bus.i_valid = 1'b0; bus.i_last = 1'b0; bus.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sym",   {30'd0, bus.o_sym},   32'd0);
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_last",  {31'd0, bus.o_last},  32'd0);
    check("rst_busy",  {31'd0, bus.o_busy},  32'd0);
    check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, bus.o_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed vector table against hand-derived symbols.
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].bits, int'(vecs[v].n), 0);
      for (int i = 0; i < int'(vecs[v].n) + KT - 1; i++) begin
        exp_sym.push_back(vecs[v].syms[2*i +: 2]);
        exp_last.push_back(i == int'(vecs[v].n) + KT - 2);
      end
      compare_obs($sformatf("vec%0d", v));
    end

    // Basic frame: o_busy drops the cycle after the o_last symbol.
    send_frame(8'b0000_1101, 4, 0);
    begin
      int c;
      c = 0;
      while (!(bus.o_valid && bus.o_last) && c < 20) begin @(posedge clk); #1; c++; end
      check("busy_at_last", {31'd0, bus.o_busy}, 32'd0);
      @(negedge clk);
      check("busy_after", {31'd0, bus.o_busy}, 32'd0);
      check("last_seen", {31'd0, bus.o_last}, 32'd1);
    end
    model_frame(8'b0000_1101, 4);
    compare_obs("basic");

    // Single-bit frame: o_ready low for the two tail cycles.
    send_bit(1'b1, 1'b1, 0);
    @(negedge clk);
    check("single_rdy1", {31'd0, bus.o_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_rdy2", {31'd0, bus.o_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_rdy3", {31'd0, bus.o_ready}, 32'd1);
    model_frame(8'b0000_0001, 1);
    compare_obs("single");

    // Backpressure while symbol 10 is held.
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_bit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_sym",   {30'd0, bus.o_sym},   32'd2);
      check("bp_valid", {31'd0, bus.o_valid}, 32'd1);
      check("bp_ready", {31'd0, bus.o_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1;
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b1, 0);
    model_frame(8'b0000_1101, 4);
    compare_obs("backpressure");

    // Back-to-back frames with no bubble between them.
    b2b_seen = 1'b0;
    send_frame(8'b0000_0011, 2, 0);
    send_frame(8'b0000_0010, 2, 0);
    model_frame(8'b0000_0011, 2);
    model_frame(8'b0000_0010, 2);
    compare_obs("b2b");
    check("b2b_no_bubble", {31'd0, b2b_seen}, 32'd1);

    // Reset during the tail of the basic frame.
    send_frame(8'b0000_1101, 4, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, bus.o_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_mid_last",  {31'd0, bus.o_last},  32'd0);
    check("rst_mid_busy",  {31'd0, bus.o_busy},  32'd0);
    @(posedge clk); #1;
    obs_sym.delete(); obs_last.delete();
    send_bit(1'b1, 1'b1, 0);
    model_frame(8'b0000_0001, 1);
    compare_obs("after_rst");

    // Random input gaps: same symbols, o_valid only follows accepted or tail bits.
    repeat (3) begin @(posedge clk); #1; end
    exp_v = 1'b0;
    tail_left = 0;
    vcheck_en = 1'b1;
    send_frame(8'b0000_1101, 4, 3);
    model_frame(8'b0000_1101, 4);
    compare_obs("gaps");
    vcheck_en = 1'b0;

    // Random frames with random gaps and random downstream stalls.
    rdy_mode = 1'b1;
    for (int f = 0; f < 12; f++) begin
      rn = $urandom_range(1, 8);
      rb = 8'($urandom);
      send_frame(rb, rn, 2);
      model_frame(rb, rn);
      compare_obs($sformatf("rand%0d", f));
    end
    rdy_mode = 1'b0;
    @(posedge clk); #2;
    bus.i_ready = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2 convolutional encoder that produces the symbol stream the Viterbi decoder consumes. It uses constraint length K=3 and generators G0=7, G1=5 (octal). It takes one information bit per handshake and emits one 2-bit symbol per bit. At the end of each frame it appends K-1 zero tail bits, so the decoder's trellis always terminates in state 0. It sits at the transmit end of the link, in front of the channel/test model, and shares the generator and symbol-order conventions with the decoder's branch-metric logic.

## Interface
- K, 3, constraint length; the shift register holds K-1 bits
- G0, 3'b111, generator for o_sym[1]; bit K-1 taps the current input, bit 0 taps the oldest register bit
- G1, 3'b101, generator for o_sym[0]
- i_clk  in  1  single clock; all logic on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_bit  in  1  information bit
- i_valid  in  1  i_bit/i_last are valid
- i_last  in  1  marks the final information bit of a frame
- o_ready  out  1  encoder accepts an input bit this cycle
- o_sym  out  2  coded symbol; [1]=G0 parity, [0]=G1 parity; [1] is transmitted first
- o_valid  out  1  o_sym holds a symbol
- o_last  out  1  o_sym is the final tail symbol of a frame
- i_ready  in  1  downstream accepts o_sym this cycle
- o_busy  out  1  a frame is in progress (state != IDLE)

## Operation
- Shift register sr[K-2:0]; sr[K-2] is the most recent bit. The encoding word is w = {u, sr}.
  - o_sym[1] = ^(w & G0)
  - o_sym[0] = ^(w & G1)
  - next sr = {u, sr[K-2:1]}
- Output slot is free when !o_valid || i_ready.
- States:
  - IDLE: sr=0. Input accepted -> DATA, or -> TAIL if i_last.
  - DATA: accept bits. Accepted bit with i_last -> TAIL with tail_cnt=0.
  - TAIL: o_ready=0. Each time the slot is free, emit the symbol for u=0 and increment tail_cnt. The symbol with tail_cnt=K-2 sets o_last=1 and returns the FSM to IDLE; sr is then 0.
- o_ready = (state != TAIL) && slot free && !i_rst.
- Input accept = i_valid && o_ready.
- Backpressure: while o_valid && !i_ready, o_sym and o_last are held stable, sr does not advance, and no input is taken.
- i_valid while o_ready=0: bit not consumed; upstream must hold it.
- Simultaneous events: output handoff (i_ready) and new accept in the same cycle gives a back-to-back symbol with no bubble.
- i_rst in any cycle forces sr=0, FSM=IDLE and tail_cnt=0. Any partial frame and held symbol are dropped.

## Timing
- Reset values: o_sym=2'b00, o_valid=0, o_last=0, o_busy=0, o_ready=0 while i_rst is high.
- o_ready=1 in the first cycle after reset deasserts.
- Latency: a bit accepted at edge n appears on o_sym/o_valid after edge n (registered output, 1 cycle).
- Throughput is 1 symbol/cycle with i_ready held high.
- A frame of N bits yields N+K-1 symbols.
- The tail occupies K-1 output cycles, with no input acceptance in that interval.
- The first bit of the next frame can be accepted in the cycle after the o_last symbol leaves TAIL.

## Structure
- viterbi_pkg holds the shared constants and types:
  - K, G0, G1 defaults, shared with the decoder's branch-metric unit
  - the symbol typedef (logic [1:0])
  - the encoder state enum {IDLE, DATA, TAIL}
- One sub-module, conv_enc_core: combinational, with inputs u and sr, producing sym and next sr.
- conv_encoder holds the FSM, tail_cnt ($clog2(K) bits), the output register and the handshake.

## Test plan
- Basic frame: bits 1,0,1,1 (last on the 4th) with i_ready=1.
  - o_sym sequence is 11,10,00,01,01,11.
  - o_last is high only on the final 11.
  - o_busy falls the cycle after.
- Single-bit frame: input 1 with i_last, from IDLE.
  - Symbols are 11,10,11; o_last on the third.
  - o_ready is low for 2 cycles after the accept.
- Backpressure: in the basic frame, drop i_ready for 3 cycles while symbol 10 is held.
  - o_sym stays 10 with o_valid high.
  - o_ready stays low and sr does not advance.
  - The full sequence is unchanged.
- Back-to-back frames: frame A = 1,1 (last), then immediately frame B = 0,1 (last).
  - Symbols are 11,01,01,11 then 00,11,10,11, with o_last on the 4th and 8th.
- Reset mid-frame: assert i_rst during the tail of the basic frame.
  - Next cycle: o_valid=0, o_last=0, o_busy=0.
  - A new frame 1 (last) yields 11,10,11.
- Gaps: random i_valid gaps with the basic frame.
  - The symbol sequence is identical to the gap-free case.
  - o_valid is low only where no bit was accepted.
